match_event_counter: RTL and testbench
======================================

# match_event_counter

Downstream consumer of the serial pattern detector's single-bit match output. Counts match events (rising edges of the detector output) over fixed windows of `WIN_LEN` cycles. Presents each window's count to a status/telemetry sink through a valid/ready handshake, and flags results lost to back-pressure.

## Interface

Parameters:
- `CNT_W`, default 8: width of the event count and of `cnt_data`.
- `WIN_LEN`, default 256: window length in clock cycles; legal range 2..65536; window counter width `$clog2(WIN_LEN)`.

Ports:
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `det_in`  in  1  match output of the upstream pattern detector.
- `en`  in  1  counting enable.
- `clr`  in  1  synchronous clear.
- `cnt_valid`  out  1  window result available.
- `cnt_ready`  in  1  sink accepts result.
- `cnt_data`  out  CNT_W  event count of the completed window.
- `overrun`  out  1  sticky flag: a window result was discarded.

## Operation

- Event detection:
  - `det_q` registers `det_in` every cycle, including in IDLE and during `clr`.
  - `event = det_in & ~det_q`. A level held high for N cycles counts once.
- Control FSM, two states:
  - IDLE: `win_cnt` = 0 and `acc` = 0; no events are counted. Moves to COUNT at the next edge when `en` = 1.
  - COUNT: every cycle, `acc` increments on `event` and `win_cnt` increments. Moves to IDLE at the next edge when `en` = 0; the partial window is discarded, `acc` and `win_cnt` are zeroed, and no result is produced.
- Window close, in a COUNT cycle with `win_cnt == WIN_LEN-1` and `en` = 1:
  - The result is `acc + event`, with overflow rule per Configuration.
  - `acc` <= 0 and `win_cnt` <= 0; the FSM stays in COUNT.
- Result register:
  - Load when `cnt_valid` = 0, or when `cnt_valid` = 1 and `cnt_ready` = 1 in the same cycle. In both cases `cnt_valid` is 1 next cycle.
  - If `cnt_valid` = 1 and `cnt_ready` = 0: the new result is discarded, `cnt_data` is held, and `overrun` <= 1.
- Handshake:
  - A transfer occurs on any cycle with `cnt_valid` and `cnt_ready` both high.
  - `cnt_data` is stable while `cnt_valid` is high and `cnt_ready` is low.
  - After a transfer with no simultaneous load, `cnt_valid` <= 0.
- `clr`, highest priority among synchronous controls:
  - FSM -> IDLE; `acc`, `win_cnt`, `cnt_valid`, `cnt_data` and `overrun` <= 0.
  - `det_q` keeps tracking.
  - A window close or transfer in the same cycle is void.
- `overrun` is cleared only by `clr` or reset.

## Timing

- Reset values, asynchronous: `cnt_valid` = 0, `cnt_data` = 0, `overrun` = 0, FSM IDLE, `det_q` = 0, `acc` = 0, `win_cnt` = 0.
- Reset assertion mid-window discards all state immediately.
- Window timing:
  - The first COUNT cycle has `win_cnt` = 0.
  - A window spans exactly `WIN_LEN` consecutive COUNT cycles.
  - Events in the IDLE->COUNT transition cycle are not counted.
- Latency:
  - An event on the last window cycle is included in that window's result.
  - `cnt_valid` rises on the edge ending the last window cycle, so a result is visible 1 cycle after the window ends.
- Throughput: with `cnt_ready` tied high, one result every `WIN_LEN` cycles, with no gaps between windows.
- `det_in` is synchronous to `clk`; no synchronizer is included.

## Configuration

- Macro `MATCH_EVENT_COUNTER_SAT_EN`.
- Defined: `acc` and the window result saturate at `2**CNT_W-1`; further events in that window are ignored.
- Undefined: `acc` and the window result wrap modulo `2**CNT_W`.
- The `overrun` flag and all other behaviour are identical in both builds.

## Test plan

- Reset: hold `rst_n` = 0 with `det_in` toggling and `en` = 1 -> `cnt_valid` = 0, `cnt_data` = 0, `overrun` = 0 throughout; no result appears earlier than `WIN_LEN` + 1 cycles after release.
- Basic count: `CNT_W`=8, `WIN_LEN`=16, `cnt_ready`=1, `en`=1; 3 one-cycle `det_in` pulses, plus a pulse on window cycle 15 -> `cnt_valid` for one cycle with `cnt_data`=4. The next window with 10 cycles of `det_in` held high -> `cnt_data`=1.
- Back-pressure: `cnt_ready`=0 across windows containing 2 then 5 events -> `cnt_data` holds 2 and `overrun`=1 after the second close. Raise `cnt_ready` -> 2 transfers and `cnt_valid` drops; `overrun` stays 1 until `clr`, which clears it.
- Simultaneous transfer and load: `cnt_ready` asserted exactly on a window-close cycle with a pending result of 2 and a new count of 5 -> 2 transfers, `cnt_data`=5 next cycle, `cnt_valid` remains 1, `overrun`=0.
- Overflow: `CNT_W`=8, `WIN_LEN`=1024, `det_in` toggling every cycle (512 edges) -> `cnt_data`=255 with the macro defined; `cnt_data`=0 without it.
- Abort paths:
  - Drop `en` after 4 events mid-window -> no result. Re-enable -> the next result counts only new events.
  - Repeat with `clr` pulsed instead, and then with `rst_n` pulsed instead -> same outcome.

Source files
------------

// File: rtl/match_event_counter.sv
// -----------------------------------------------------------------------------
// match_event_counter
//
// Counts match events from a serial pattern detector over fixed windows of
// WIN_LEN clock cycles. A match event is a rising edge of det_in, so a level
// held high for several cycles counts once. Each completed window's count is
// offered to a telemetry sink over a valid/ready handshake. If a new result
// arrives while the previous one is still waiting, the new result is dropped
// and the sticky overrun flag is set.
//
// Parameters:
//   CNT_W    width of the event accumulator and of cnt_data
//   WIN_LEN  window length in clock cycles (2..65536)
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   det_in     in   match output of the upstream detector (synchronous to clk)
//   en         in   counting enable; dropping it abandons the current window
//   clr        in   synchronous clear of the FSM, counters, result and overrun
//   cnt_valid  out  a window result is waiting on cnt_data
//   cnt_ready  in   sink accepts the result this cycle
//   cnt_data   out  event count of the most recently completed window
//   overrun    out  sticky: at least one window result was discarded
//
// Build option:
//   MATCH_EVENT_COUNTER_SAT_EN  when defined, the accumulator saturates at
//                               2**CNT_W-1; otherwise it wraps modulo 2**CNT_W.
// -----------------------------------------------------------------------------

module match_event_counter #(
    parameter int CNT_W   = 8,
    parameter int WIN_LEN = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             det_in,
    input  logic             en,
    input  logic             clr,
    output logic             cnt_valid,
    input  logic             cnt_ready,
    output logic [CNT_W-1:0] cnt_data,
    output logic             overrun
);

    localparam int               WIN_W    = $clog2(WIN_LEN);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_COUNT = 1'b1
    } state_e;

    // -------------------------------------------------------------------------
    // Declarations
    // -------------------------------------------------------------------------
    state_e             state_q, state_d;
    logic               det_q;
    logic [CNT_W-1:0]   acc_q, acc_d;
    logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
    logic               cnt_valid_q, cnt_valid_d;
    logic [CNT_W-1:0]   cnt_data_q, cnt_data_d;
    logic               overrun_q, overrun_d;

    logic               event_w;     // rising edge of det_in this cycle
    logic               count_act;   // this cycle is a counted window cycle
    logic               win_last;    // window counter sits on its last value
    logic               win_close;   // window completes at the end of this cycle
    logic [CNT_W-1:0]   acc_sum;     // accumulator including this cycle's event

    // -------------------------------------------------------------------------
    // Edge detector. det_q tracks det_in in every state and during clr so the
    // first cycle after an idle period still sees the true previous level.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples the pre-edge value of its neighbours, independent of
        // statement or process ordering.
        if (!rst_n) begin
            det_q <= 1'b0;
        end else begin
            det_q <= det_in;
        end
    end

    assign event_w = det_in & ~det_q;

    // -------------------------------------------------------------------------
    // Control FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Control FSM: next-state logic. clr overrides en in either state.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block leaves it unassigned (which would infer a latch).
        state_d = state_q;
        if (clr) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE:  if (en)  state_d = S_COUNT;
                S_COUNT: if (!en) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Control FSM: outputs. A cycle is counted only in COUNT with en held and
    // no clr; the IDLE->COUNT transition cycle is therefore never counted, and
    // a close coinciding with clr or with en falling produces no result.
    // -------------------------------------------------------------------------
    always_comb begin
        count_act = 1'b0;
        if (state_q == S_COUNT && en && !clr) begin
            count_act = 1'b1;
        end
        win_last  = (win_cnt_q == WIN_LAST);
        win_close = count_act && win_last;
    end

    // -------------------------------------------------------------------------
    // Accumulator increment, including an event on the current cycle so that
    // an event on the last window cycle lands in that window's result.
    // -------------------------------------------------------------------------
    always_comb begin
        acc_sum = acc_q;
`ifdef MATCH_EVENT_COUNTER_SAT_EN
        if (event_w && (acc_q != CNT_MAX)) begin
            acc_sum = acc_q + CNT_W'(1);
        end
`else
        if (event_w) begin
            acc_sum = acc_q + CNT_W'(1);
        end
`endif
    end

    // -------------------------------------------------------------------------
    // Window counter and accumulator. Outside a counted mid-window cycle both
    // return to zero: that single rule covers IDLE, an en-drop abort, clr and
    // the start of the next back-to-back window after a close.
    // -------------------------------------------------------------------------
    always_comb begin
        acc_d     = '0;
        win_cnt_d = '0;
        if (count_act && !win_last) begin
            acc_d     = acc_sum;
            win_cnt_d = win_cnt_q + WIN_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            win_cnt_q <= '0;
        end else begin
            acc_q     <= acc_d;
            win_cnt_q <= win_cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Result register and handshake.
    //   - A transfer (valid & ready) empties the slot unless a new result is
    //     loaded on the same edge.
    //   - A closing window loads when the slot is empty or being emptied this
    //     cycle; otherwise the new result is dropped and overrun is set, so
    //     cnt_data stays stable while the sink stalls.
    // -------------------------------------------------------------------------
    always_comb begin
        cnt_valid_d = cnt_valid_q;
        cnt_data_d  = cnt_data_q;
        overrun_d   = overrun_q;
        if (clr) begin
            cnt_valid_d = 1'b0;
            cnt_data_d  = '0;
            overrun_d   = 1'b0;
        end else begin
            if (cnt_valid_q && cnt_ready) begin
                cnt_valid_d = 1'b0;
            end
            if (win_close) begin
                if (!cnt_valid_q || cnt_ready) begin
                    cnt_valid_d = 1'b1;
                    cnt_data_d  = acc_sum;
                end else begin
                    overrun_d   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_valid_q <= 1'b0;
            cnt_data_q  <= '0;
            overrun_q   <= 1'b0;
        end else begin
            cnt_valid_q <= cnt_valid_d;
            cnt_data_q  <= cnt_data_d;
            overrun_q   <= overrun_d;
        end
    end

    assign cnt_valid = cnt_valid_q;
    assign cnt_data  = cnt_data_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_match_event_counter.sv
// -----------------------------------------------------------------------------
// tb_match_event_counter
//
// Directed bench for match_event_counter. u_dut runs with CNT_W=8, WIN_LEN=16
// and carries the table of per-cycle vectors plus the reset sequences. u_ovf
// runs with WIN_LEN=1024 on the same inputs and is only examined in the
// overflow sequence; its sink is always ready.
//
// Each vector drives det_in/en/clr/cnt_ready for one cycle, then compares the
// selected outputs 1 time unit after the closing clock edge.
// -----------------------------------------------------------------------------

module tb_match_event_counter;

    localparam logic [2:0] M_NONE = 3'b000;
    localparam logic [2:0] M_V    = 3'b001;
    localparam logic [2:0] M_D    = 3'b010;
    localparam logic [2:0] M_O    = 3'b100;
    localparam logic [2:0] M_ALL  = 3'b111;

    typedef struct {
        logic       det;
        logic       en;
        logic       clr;
        logic       rdy;
        logic [2:0] mask;   // which outputs to compare after this cycle
        logic       ev;     // expected cnt_valid
        logic [7:0] ed;     // expected cnt_data
        logic       eo;     // expected overrun
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       det_in;
    logic       en;
    logic       clr;
    logic       cnt_ready;
    logic       cnt_valid;
    logic [7:0] cnt_data;
    logic       overrun;

    logic       ovf_ready;
    logic       ovf_valid;
    logic [7:0] ovf_data;
    logic       ovf_overrun;

    int   n_chk = 0;
    int   n_err = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    match_event_counter #(.CNT_W(8), .WIN_LEN(16)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .det_in    (det_in),
        .en        (en),
        .clr       (clr),
        .cnt_valid (cnt_valid),
        .cnt_ready (cnt_ready),
        .cnt_data  (cnt_data),
        .overrun   (overrun)
    );

    match_event_counter #(.CNT_W(8), .WIN_LEN(1024)) u_ovf (
        .clk       (clk),
        .rst_n     (rst_n),
        .det_in    (det_in),
        .en        (en),
        .clr       (clr),
        .cnt_valid (ovf_valid),
        .cnt_ready (ovf_ready),
        .cnt_data  (ovf_data),
        .overrun   (ovf_overrun)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void push(input logic det, input logic en_v, input logic clr_v,
                                 input logic rdy, input logic [2:0] mask,
                                 input logic ev, input logic [7:0] ed, input logic eo);
        vec_t v;
        v.det = det; v.en = en_v; v.clr = clr_v; v.rdy = rdy;
        v.mask = mask; v.ev = ev; v.ed = ed; v.eo = eo;
        tbl.push_back(v);
    endfunction

    // n cycles with det_in taken from det_mask bit i on the i-th cycle
    function automatic void push_run(input int n, input logic [31:0] det_mask,
                                     input logic en_v, input logic clr_v, input logic rdy,
                                     input logic [2:0] mask, input logic ev,
                                     input logic [7:0] ed, input logic eo);
        for (int i = 0; i < n; i++) begin
            push(det_mask[i], en_v, clr_v, rdy, mask, ev, ed, eo);
        end
    endfunction

    task automatic apply(input vec_t v, input string tag);
        det_in    = v.det;
        en        = v.en;
        clr       = v.clr;
        cnt_ready = v.rdy;
        @(posedge clk);
        #1;
        if (v.mask[0]) check({tag, " valid"},   32'(cnt_valid), 32'(v.ev));
        if (v.mask[1]) check({tag, " data"},    32'(cnt_data),  32'(v.ed));
        if (v.mask[2]) check({tag, " overrun"}, 32'(overrun),   32'(v.eo));
    endtask

    task automatic cyc(input logic det, input logic en_v, input logic clr_v, input logic rdy,
                       input logic [2:0] mask, input logic ev, input logic [7:0] ed,
                       input logic eo, input string tag);
        vec_t v;
        v.det = det; v.en = en_v; v.clr = clr_v; v.rdy = rdy;
        v.mask = mask; v.ev = ev; v.ed = ed; v.eo = eo;
        apply(v, tag);
    endtask

    initial begin
        logic [7:0]  ovf_exp;
        logic [15:0] m_mask;

`ifdef MATCH_EVENT_COUNTER_SAT_EN
        ovf_exp = 8'd255;   // 512 edges saturate at the 8-bit maximum
`else
        ovf_exp = 8'd0;     // 512 edges wrap to 512 mod 256
`endif

        // ---------------- vector table (starts from IDLE, det_q = 0) --------
        // Transition cycle with det high: this edge must not be counted.
        push(1, 1, 0, 1, M_V, 0, 0, 0);
        // Window A: pulses on cycles 3, 6, 9 and the last cycle 15 -> 4.
        push_run(15, 32'h0248, 1, 0, 1, M_V, 0, 0, 0);
        push(1, 1, 0, 1, M_ALL, 1, 8'd4, 0);
        // Window B: result of A transfers on cycle 0; det high on 2..11 -> 1.
        push(0, 1, 0, 1, M_V, 0, 0, 0);
        push_run(14, 32'h07FE, 1, 0, 1, M_V, 0, 0, 0);
        push(0, 1, 0, 1, M_ALL, 1, 8'd1, 0);
        // Window C: B transfers on cycle 0, then sink stalls; events 4, 10 -> 2.
        push(0, 1, 0, 1, M_V, 0, 0, 0);
        push_run(14, 32'h0208, 1, 0, 0, M_V, 0, 0, 0);
        push(0, 1, 0, 0, M_ALL, 1, 8'd2, 0);
        // Window D: still stalled, 5 events -> result dropped, 2 held, overrun.
        push_run(15, 32'h00AA, 1, 0, 0, M_ALL, 1, 8'd2, 0);
        push(1, 1, 0, 0, M_ALL, 1, 8'd2, 1);
        // Sink ready: pending 2 transfers, valid drops, overrun stays.
        push(0, 1, 0, 1, M_V | M_O, 0, 0, 1);
        push_run(3, 32'h0, 1, 0, 1, M_V | M_O, 0, 0, 1);
        // clr clears overrun and everything else; back to IDLE.
        push(0, 1, 1, 1, M_ALL, 0, 0, 0);
        // Transition, then window F (stalled) with events 2, 5 -> 2 pending.
        push(0, 1, 0, 0, M_V, 0, 0, 0);
        push_run(15, 32'h0024, 1, 0, 0, M_V, 0, 0, 0);
        push(0, 1, 0, 0, M_ALL, 1, 8'd2, 0);
        // Window G: stalled until ready rises exactly on the close; 5 events.
        push_run(15, 32'h0055, 1, 0, 0, M_ALL, 1, 8'd2, 0);
        push(1, 1, 0, 1, M_ALL, 1, 8'd5, 0);
        // Window H: 5 transfers, 4 events, then en drops on cycle 9 -> no result.
        push(0, 1, 0, 1, M_V, 0, 0, 0);
        push_run(8, 32'h0055, 1, 0, 1, M_V, 0, 0, 0);
        push(0, 0, 0, 1, M_V, 0, 0, 0);
        push_run(20, 32'h0005_5555, 0, 0, 1, M_V, 0, 0, 0);
        // Re-enable: window I counts only its own events 4, 8, 12 -> 3.
        push(0, 1, 0, 1, M_V, 0, 0, 0);
        push_run(15, 32'h1110, 1, 0, 1, M_V, 0, 0, 0);
        push(0, 1, 0, 1, M_ALL, 1, 8'd3, 0);
        // Window J: 3 transfers, 4 events, then clr on cycle 9.
        push(0, 1, 0, 1, M_V, 0, 0, 0);
        push_run(8, 32'h0055, 1, 0, 1, M_V, 0, 0, 0);
        push(0, 1, 1, 1, M_ALL, 0, 0, 0);
        // Window K: clr lands on the closing cycle, so the close is void.
        push(0, 1, 0, 1, M_V, 0, 0, 0);
        push_run(15, 32'h0081, 1, 0, 1, M_V, 0, 0, 0);
        push(0, 1, 1, 1, M_ALL, 0, 0, 0);
        // Window L: only new events 3, 9 -> 2.
        push(0, 1, 0, 1, M_V, 0, 0, 0);
        push_run(15, 32'h0208, 1, 0, 1, M_V, 0, 0, 0);
        push(0, 1, 0, 1, M_ALL, 1, 8'd2, 0);

        // ---------------- reset held with activity on the inputs ------------
        rst_n = 1'b0; en = 1'b1; clr = 1'b0; cnt_ready = 1'b1; det_in = 1'b0;
        ovf_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            det_in = i[0];
            @(posedge clk);
            #1;
            check($sformatf("reset%0d valid", i),   32'(cnt_valid), 32'd0);
            check($sformatf("reset%0d data", i),    32'(cnt_data),  32'd0);
            check($sformatf("reset%0d overrun", i), 32'(overrun),   32'd0);
        end
        // Release with en high: first result exactly WIN_LEN+1 edges later.
        rst_n  = 1'b1;
        det_in = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("post-reset edge %0d valid", i), 32'(cnt_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        check("post-reset edge 17 valid", 32'(cnt_valid), 32'd1);
        check("post-reset edge 17 data",  32'(cnt_data),  32'd0);
        cyc(0, 0, 1, 1, M_ALL, 0, 0, 0, "pre-table clr");
        cyc(0, 0, 0, 1, M_V,   0, 0, 0, "pre-table idle");

        // ---------------- table ----------------
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // ---------------- reset as an abort path ----------------
        // Result 2 from window L is pending with the sink stalled; window M
        // collects 4 events, then rst_n asserts mid-cycle.
        m_mask = 16'h00AA;
        for (int i = 0; i < 9; i++) begin
            cyc(m_mask[i], 1, 0, 0, M_ALL, 1, 8'd2, 0, $sformatf("winM c%0d", i));
        end
        det_in = 1'b0; en = 1'b1; clr = 1'b0; cnt_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset valid",   32'(cnt_valid), 32'd0);
        check("async reset data",    32'(cnt_data),  32'd0);
        check("async reset overrun", 32'(overrun),   32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        // Transition cycle, then a window with a single event on cycle 6.
        cyc(0, 1, 0, 1, M_V, 0, 0, 0, "winN trans");
        m_mask = 16'h0040;
        for (int i = 0; i < 15; i++) begin
            cyc(m_mask[i], 1, 0, 1, M_V, 0, 0, 0, $sformatf("winN c%0d", i));
        end
        cyc(0, 1, 0, 1, M_ALL, 1, 8'd1, 0, "winN close");

        // ---------------- overflow, 1024-cycle window ----------------
        cyc(0, 0, 1, 1, M_ALL, 0, 0, 0, "ovf clr");
        cyc(0, 1, 0, 1, M_V,   0, 0, 0, "ovf trans");
        for (int i = 0; i < 1024; i++) begin
            det_in = (i % 2 == 0);
            @(posedge clk);
            #1;
            if (i == 1022) begin
                check("ovf before close valid", 32'(ovf_valid), 32'd0);
            end
            if (i == 1023) begin
                check("ovf close valid",     32'(ovf_valid),   32'd1);
                check("ovf close data",      32'(ovf_data),    32'(ovf_exp));
                check("ovf close overrun",   32'(ovf_overrun), 32'd0);
                // The 16-cycle instance closes on the same edge with 8 edges.
                check("toggle win16 valid",  32'(cnt_valid),   32'd1);
                check("toggle win16 data",   32'(cnt_data),    32'd8);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
